// File: rtl/slave_node_if.sv
// Connections between a slave node and its chain neighbours: serial data,
// the master's shift enable, and the node's registered status outputs.
interface slave_node_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serial_in;
  logic             shift_en_in;
  logic             serial_out;
  logic [WIDTH-1:0] leds;
  logic             shift_pulse;
  logic             frame_done;
  logic             link_lost;

  modport slave (
    input  serial_in, shift_en_in,
    output serial_out, leds, shift_pulse, frame_done, link_lost
  );

  modport master (
    output serial_in, shift_en_in,
    input  serial_out, leds, shift_pulse, frame_done, link_lost
  );
endinterface

// File: rtl/slave_node.sv
// Daisy-chained shift-register node: a debounced shift enable clocks serial
// data through a local register, with frame and link-timeout status.
module slave_node #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      FILTER_CYCLES  = 1,
  parameter logic [WIDTH-1:0] INIT_PATTERN   = '0,
  parameter int unsigned      TIMEOUT_CYCLES = 150_000_000
) (
  input  logic        clk,
  input  logic        rst,
  slave_node_if.slave bus
);
  localparam int unsigned       CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned       IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        FILT       = 4'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;

  logic              sin_q1, sin_s, en_q1, en_s;
  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic              accept_c;
  logic [WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]  shift_cnt;
  logic [IDLE_W-1:0] idle_cnt, idle_next;

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q1 <= 1'b0;
      sin_s  <= 1'b0;
      en_q1  <= 1'b0;
      en_s   <= 1'b0;
    end else begin
      sin_q1 <= bus.serial_in;
      sin_s  <= sin_q1;
      en_q1  <= bus.shift_en_in;
      en_s   <= en_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Enable filter: a shift is accepted once per qualified rising run
  always_comb begin
    state_next = state;
    count_next = count;
    accept_c   = 1'b0;
    unique case (state)
      LOW: begin
        if (en_s) begin
          if (FILT <= 4'd1) begin
            state_next = HIGH;
            count_next = '0;
            accept_c   = 1'b1;
          end else begin
            state_next = RISE_CHK;
            count_next = 4'd1;
          end
        end
      end
      RISE_CHK: begin
        if (en_s) begin
          count_next = count + 4'd1;
          if (count + 4'd1 >= FILT) begin
            state_next = HIGH;
            count_next = '0;
            accept_c   = 1'b1;
          end
        end else begin
          state_next = LOW;
          count_next = '0;
        end
      end
      HIGH: begin
        if (!en_s) begin
          if (FILT <= 4'd1) begin
            state_next = LOW;
            count_next = '0;
          end else begin
            state_next = FALL_CHK;
            count_next = 4'd1;
          end
        end
      end
      FALL_CHK: begin
        if (!en_s) begin
          count_next = count + 4'd1;
          if (count + 4'd1 >= FILT) begin
            state_next = LOW;
            count_next = '0;
          end
        end else begin
          state_next = HIGH;
          count_next = '0;
        end
      end
      default: begin
        state_next = LOW;
        count_next = '0;
      end
    endcase
  end

  // Idle counter saturates; an accepted shift always wins over the timeout
  always_comb begin
    idle_next = idle_cnt;
    if (accept_c) begin
      idle_next = '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_next = idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg       <= INIT_PATTERN;
      shift_cnt       <= '0;
      idle_cnt        <= '0;
      bus.leds        <= INIT_PATTERN;
      bus.serial_out  <= 1'b0;
      bus.shift_pulse <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.link_lost   <= 1'b0;
    end else begin
      idle_cnt        <= idle_next;
      bus.link_lost   <= (idle_next == IDLE_MAX);
      bus.shift_pulse <= accept_c;
      bus.frame_done  <= accept_c && (shift_cnt == LAST_SHIFT);
      if (accept_c) begin
        shift_reg      <= {shift_reg[WIDTH-2:0], sin_s};
        bus.leds       <= {shift_reg[WIDTH-2:0], sin_s};
        bus.serial_out <= shift_reg[WIDTH-1];
        shift_cnt      <= (shift_cnt == LAST_SHIFT) ? '0 : shift_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_slave_node.sv
// Bench for slave_node: three parameterisations sharing one clock, a scored
// shift sequence on the default node plus filter, timeout and reset corners.
module tb_slave_node;
  logic clk;
  logic rst_d, rst_f, rst_i;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  typedef struct {
    logic       sin;
    logic [7:0] leds;
    logic       so;
    logic       fd;
  } vec_t;

  typedef struct {
    logic [7:0] leds;
    logic       so;
    logic       fd;
  } sb_t;

  vec_t tbl [16];
  sb_t  sbq [$];

  slave_node_if #(.WIDTH(8)) bd ();
  slave_node_if #(.WIDTH(8)) bf ();
  slave_node_if #(.WIDTH(8)) bi ();

  slave_node #(.WIDTH(8), .FILTER_CYCLES(1), .INIT_PATTERN(8'h00), .TIMEOUT_CYCLES(20))
    dut_d (.clk(clk), .rst(rst_d), .bus(bd));
  slave_node #(.WIDTH(8), .FILTER_CYCLES(3), .INIT_PATTERN(8'h00), .TIMEOUT_CYCLES(1000))
    dut_f (.clk(clk), .rst(rst_f), .bus(bf));
  slave_node #(.WIDTH(8), .FILTER_CYCLES(1), .INIT_PATTERN(8'h81), .TIMEOUT_CYCLES(1000))
    dut_i (.clk(clk), .rst(rst_i), .bus(bi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pops one expected record per shift_pulse seen on the default node
  task automatic monitor_d();
    logic prev = 1'b0;
    sb_t  e;
    while (mon_on) begin
      @(negedge clk);
      if (bd.shift_pulse) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual=1 expected=0 leds=%0h", bd.leds);
        end else begin
          e = sbq.pop_front();
          chk("sb_leds", 32'(bd.leds), 32'(e.leds));
          chk("sb_serial_out", 32'(bd.serial_out), 32'(e.so));
          chk("sb_frame_done", 32'(bd.frame_done), 32'(e.fd));
        end
        chk("pulse_width", 32'(prev), 32'd0);
      end else begin
        chk("frame_without_pulse", 32'(bd.frame_done), 32'd0);
      end
      prev = bd.shift_pulse;
    end
  endtask

  task automatic reset_d();
    bd.shift_en_in = 1'b0;
    @(posedge clk); #1 rst_d = 1'b1;
    @(posedge clk); #1 rst_d = 1'b0;
  endtask

  task automatic d_pulse(input logic b);
    @(posedge clk); #1;
    bd.serial_in   = b;
    bd.shift_en_in = 1'b1;
    @(posedge clk); #1;
    bd.shift_en_in = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic run_f(input int hi_len, input int cycles, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    @(posedge clk); #1;
    bf.serial_in   = 1'b1;
    bf.shift_en_in = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      if (k == hi_len) bf.shift_en_in = 1'b0;
      if (bf.shift_pulse) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  initial begin
    int np, fe;
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h05, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h0B, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h16, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h2C, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h59, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'hB2, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h65, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'hCB, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h97, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h2F, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h5E, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'hBC, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h78, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'hF0, 1'b0, 1'b1};

    rst_d = 1'b1; rst_f = 1'b1; rst_i = 1'b1;
    bd.serial_in = 1'b0; bd.shift_en_in = 1'b0;
    bf.serial_in = 1'b0; bf.shift_en_in = 1'b0;
    bi.serial_in = 1'b0; bi.shift_en_in = 1'b0;
    repeat (2) @(posedge clk);

    mon_on = 1'b1;
    fork
      monitor_d();
    join_none

    // Reset values, link timeout, then a single shift clears it
    reset_d();
    @(negedge clk);
    chk("rst_leds", 32'(bd.leds), 32'h00);
    chk("rst_serial_out", 32'(bd.serial_out), 32'd0);
    chk("rst_shift_pulse", 32'(bd.shift_pulse), 32'd0);
    chk("rst_frame_done", 32'(bd.frame_done), 32'd0);
    chk("rst_link_lost", 32'(bd.link_lost), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 19) chk("link_lost_before_timeout", 32'(bd.link_lost), 32'd0);
      if (k == 20) chk("link_lost_at_timeout", 32'(bd.link_lost), 32'd1);
    end
    sbq.push_back('{8'h01, 1'b0, 1'b0});
    bd.serial_in   = 1'b1;
    bd.shift_en_in = 1'b1;
    @(posedge clk); #1 bd.shift_en_in = 1'b0;
    @(negedge clk);
    chk("link_lost_held", 32'(bd.link_lost), 32'd1);
    @(negedge clk);
    chk("latency_edge2_leds", 32'(bd.leds), 32'h00);
    chk("latency_edge2_pulse", 32'(bd.shift_pulse), 32'd0);
    chk("latency_edge2_link_lost", 32'(bd.link_lost), 32'd1);
    @(negedge clk);
    chk("latency_edge3_leds", 32'(bd.leds), 32'h01);
    chk("latency_edge3_serial_out", 32'(bd.serial_out), 32'd0);
    chk("latency_edge3_pulse", 32'(bd.shift_pulse), 32'd1);
    chk("link_lost_cleared", 32'(bd.link_lost), 32'd0);
    @(negedge clk);
    chk("pulse_one_cycle", 32'(bd.shift_pulse), 32'd0);
    repeat (4) @(posedge clk);

    // Shift accepted on the edge the idle count would hit the timeout
    reset_d();
    @(negedge clk);
    for (int k = 1; k <= 17; k++) @(negedge clk);
    sbq.push_back('{8'h01, 1'b0, 1'b0});
    bd.serial_in   = 1'b1;
    bd.shift_en_in = 1'b1;
    @(posedge clk); #1 bd.shift_en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("race_pre_link_lost", 32'(bd.link_lost), 32'd0);
    @(negedge clk);
    chk("race_pulse", 32'(bd.shift_pulse), 32'd1);
    chk("race_link_lost", 32'(bd.link_lost), 32'd0);
    @(negedge clk);
    chk("race_link_lost_after", 32'(bd.link_lost), 32'd0);
    repeat (3) @(posedge clk);

    // Two full frames from reset through the scoreboard
    reset_d();
    for (int n = 0; n < 16; n++) begin
      sbq.push_back('{tbl[n].leds, tbl[n].so, tbl[n].fd});
      d_pulse(tbl[n].sin);
    end

    // Enable held high: exactly one shift
    sbq.push_back('{8'hE1, 1'b1, 1'b0});
    @(posedge clk); #1;
    bd.serial_in   = 1'b1;
    bd.shift_en_in = 1'b1;
    repeat (20) @(posedge clk);
    #1 bd.shift_en_in = 1'b0;
    repeat (6) @(posedge clk);
    chk("hold_leds", 32'(bd.leds), 32'hE1);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    mon_on = 1'b0;

    // Filter of three: short glitch ignored, long run shifts once on edge 5
    @(posedge clk); #1 rst_f = 1'b0;
    run_f(2, 12, np, fe);
    chk("glitch_pulses", 32'(np), 32'd0);
    chk("glitch_leds", 32'(bf.leds), 32'h00);
    run_f(10, 20, np, fe);
    chk("filter_pulses", 32'(np), 32'd1);
    chk("filter_edge", 32'(fe), 32'd5);
    chk("filter_leds", 32'(bf.leds), 32'h01);

    // Reset on the accepting edge discards the shift; held enable rearms
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("init_leds", 32'(bi.leds), 32'h81);
    chk("init_serial_out", 32'(bi.serial_out), 32'd0);
    bi.serial_in   = 1'b1;
    bi.shift_en_in = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    chk("rst_race_leds", 32'(bi.leds), 32'h81);
    chk("rst_race_pulse", 32'(bi.shift_pulse), 32'd0);
    chk("rst_race_serial_out", 32'(bi.serial_out), 32'd0);
    for (int k = 4; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("rearm_no_early_pulse", 32'(bi.shift_pulse), 32'd0);
    end
    @(posedge clk); #1;
    chk("rearm_pulse", 32'(bi.shift_pulse), 32'd1);
    chk("rearm_leds", 32'(bi.leds), 32'h03);
    chk("rearm_serial_out", 32'(bi.serial_out), 32'd1);
    bi.shift_en_in = 1'b0;
    @(posedge clk); #1;
    chk("rearm_pulse_end", 32'(bi.shift_pulse), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("rearm_hold_leds", 32'(bi.leds), 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/slave_node.md
SLAVE_NODE -- requirements
Module: slave_node

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, shift register and LED width.
REQ-002 FILTER_CYCLES, default 1, SHALL set the consecutive synchronized-high samples required to accept a shift enable (range 1..15).
REQ-003 INIT_PATTERN, default 8'h00, SHALL be the shift register reset value.
REQ-004 TIMEOUT_CYCLES, default 150_000_000, SHALL set the idle cycles before link_lost asserts.
REQ-005 clk  input  1  the one system clock; all state SHALL update on its rising edge only.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 serial_in  input  1  data bit from the upstream board, asynchronous to clk.
REQ-008 shift_en_in  input  1  shift enable from the master board, asynchronous to clk.
REQ-009 serial_out  output  1  registered MSB passed to the downstream board.
REQ-010 leds  output  WIDTH  registered copy of the shift register.
REQ-011 shift_pulse  output  1  one-cycle strobe, high on each accepted shift.
REQ-012 frame_done  output  1  one-cycle strobe, high on every WIDTH-th accepted shift.
REQ-013 link_lost  output  1  level, high while no shift accepted within TIMEOUT_CYCLES.

Function
REQ-014 serial_in and shift_en_in SHALL each pass through a two-flop synchronizer; sin_s and en_s denote the second-stage outputs.
REQ-015 An enable-filter FSM SHALL have states LOW, RISE_CHK, HIGH, FALL_CHK with a 4-bit run counter.
REQ-016 LOW: en_s=1 -> RISE_CHK with count=1, unless FILTER_CYCLES=1, in which case -> HIGH and accept a shift on that edge.
REQ-017 RISE_CHK: en_s=1 increments count; on reaching FILTER_CYCLES -> HIGH and accept a shift on that edge; en_s=0 -> LOW, count cleared, no shift.
REQ-018 HIGH: en_s=0 -> FALL_CHK (count=1), or -> LOW directly if FILTER_CYCLES=1; no further shift while en_s stays high.
REQ-019 FALL_CHK: en_s=0 increments count; on reaching FILTER_CYCLES -> LOW; en_s=1 -> HIGH, no shift.
REQ-020 Latency: the shift SHALL take effect on the (FILTER_CYCLES+2)-th rising edge after shift_en_in is first sampled high. Default: 3rd edge.
REQ-021 On an accepted shift, shift_reg SHALL load {shift_reg[WIDTH-2:0], sin_s}, serial_out SHALL load the old shift_reg[WIDTH-1], and leds SHALL load the new shift_reg value, all on the same edge.
REQ-022 shift_pulse SHALL be high for exactly the cycle following the accepting edge.
REQ-023 A shift counter modulo WIDTH SHALL increment per accepted shift. frame_done SHALL pulse with shift_pulse when the counter wraps from WIDTH-1 to 0.
REQ-024 The idle counter SHALL clear on each accepted shift and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-025 link_lost SHALL assert on the cycle the idle count reaches TIMEOUT_CYCLES, and SHALL deassert on the cycle after the next accepted shift.
REQ-026 Boundary: shift_en_in held high indefinitely SHALL yield exactly one shift. A high run shorter than FILTER_CYCLES synchronized samples SHALL yield none.
REQ-027 Boundary: a shift accepted on the same edge the idle count reaches TIMEOUT_CYCLES SHALL win, so link_lost stays low.
REQ-028 Without shifts, outputs SHALL hold their values indefinitely.

Reset
REQ-029 rst=1 at a rising edge SHALL, on that edge, set shift_reg=INIT_PATTERN, leds=INIT_PATTERN, serial_out=0, shift_pulse=0, frame_done=0, link_lost=0, FSM=LOW, and clear all counters and synchronizer flops, overriding any shift in progress.
REQ-030 A shift whose accepting edge coincides with rst=1 SHALL be discarded.
REQ-031 After rst deasserts, an enable that is still high SHALL be treated as a new rising enable.

Verification
REQ-032 Defaults, reset, serial_in=1, one 1-cycle shift_en_in pulse -> on the 3rd edge leds=8'h01, serial_out=0, shift_pulse high for one cycle.
REQ-033 Defaults, eight pulses with serial_in pattern 1,0,1,1,0,0,1,0 -> leds=8'hB2, frame_done high with the 8th shift_pulse only, serial_out carried each previous MSB.
REQ-034 FILTER_CYCLES=3, 2-cycle enable glitch, then a 10-cycle enable -> no shift for the glitch, exactly one shift on the 5th edge of the long enable.
REQ-035 TIMEOUT_CYCLES=20, no enables after reset -> link_lost rises after 20 cycles, then clears one cycle after the next accepted shift.
REQ-036 INIT_PATTERN=8'h81, rst asserted on the accepting edge of a shift -> leds=8'h81, no shift_pulse, FSM LOW.
